// File: rtl/ram_responder.sv
// ram_responder: multi-cycle data-memory responder behind a four-phase MOV/MFC
// handshake. Byte-addressed, big-endian, byte/halfword/word with optional sign
// extension on reads.
module ram_responder #(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned LATENCY = 2,
  localparam int unsigned AW = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mov,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    size,
  input  logic          sign,
  input  logic [31:0]   data_in,
  output logic [31:0]   data_out,
  output logic          mfc,
  output logic          err,
  output logic          busy
);

  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  // Request captured at the sample edge; live inputs are ignored afterwards.
  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          sign;
    logic [31:0]   data;
    logic          bad;
  } reqT;

  stateT         state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  reqT           req, reqNext;
  logic          mfcNext, errNext, busyNext;
  logic [31:0]   dataOutNext;

  logic          reqBad;
  logic          memWe;
  logic [3:0]    memBe;
  logic [31:0]   memWdata;
  logic [31:0]   rdWord;
  logic [7:0]    rdByte;
  logic [15:0]   rdHalf;
  logic [31:0]   readData;
  logic [1:0]    lane;
  logic [AW-3:0] wordIdx;

  // Word-organised array; bit lane 31:24 holds the lowest byte address.
  logic [31:0] mem [WORDS];

  // Alignment / reserved-size check on the live request.
  always_comb begin
    reqBad = (size == 2'b11)
           | ((size == 2'b01) & addr[0])
           | ((size == 2'b10) & (addr[1:0] != 2'b00));
  end

  // Big-endian extraction of the latched access from its containing word.
  always_comb begin
    lane    = req.addr[1:0];
    wordIdx = req.addr[AW-1:2];
    rdWord  = mem[wordIdx];
    unique case (lane)
      2'd0:    rdByte = rdWord[31:24];
      2'd1:    rdByte = rdWord[23:16];
      2'd2:    rdByte = rdWord[15:8];
      default: rdByte = rdWord[7:0];
    endcase
    rdHalf = lane[1] ? rdWord[15:0] : rdWord[31:16];
    unique case (req.size)
      2'b00:   readData = {{24{req.sign & rdByte[7]}}, rdByte};
      2'b01:   readData = {{16{req.sign & rdHalf[15]}}, rdHalf};
      default: readData = rdWord;
    endcase
  end

  // Next-state, handshake outputs and memory write strobe.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    reqNext     = req;
    mfcNext     = mfc;
    errNext     = err;
    dataOutNext = data_out;
    memWe       = 1'b0;
    memBe       = 4'b0000;
    memWdata    = 32'h0;
    unique case (state)
      IDLE: begin
        if (mov) begin
          reqNext.rw   = rw;
          reqNext.addr = addr;
          reqNext.size = size;
          reqNext.sign = sign;
          reqNext.data = data_in;
          reqNext.bad  = reqBad;
          cntNext      = CW'(LATENCY - 1);
          stateNext    = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cntNext = cnt - CW'(1);
        end else begin
          stateNext = DONE;
          mfcNext   = 1'b1;
          errNext   = req.bad;
          if (!req.bad) begin
            if (req.rw) begin
              dataOutNext = readData;
            end else begin
              memWe = 1'b1;
              unique case (req.size)
                2'b00: begin
                  memWdata = {4{req.data[7:0]}};
                  memBe    = 4'b1000 >> lane;
                end
                2'b01: begin
                  memWdata = {2{req.data[15:0]}};
                  memBe    = lane[1] ? 4'b0011 : 4'b1100;
                end
                default: begin
                  memWdata = req.data;
                  memBe    = 4'b1111;
                end
              endcase
            end
          end
        end
      end
      DONE: begin
        if (!mov) begin
          mfcNext   = 1'b0;
          errNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    busyNext = (stateNext != IDLE);
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      req      <= '0;
      mfc      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      data_out <= 32'h0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      req      <= reqNext;
      mfc      <= mfcNext;
      err      <= errNext;
      busy     <= busyNext;
      data_out <= dataOutNext;
    end
  end

  // Byte-lane writes; a reset on the access edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (memBe[i]) mem[wordIdx][8*i +: 8] <= memWdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed table, handshake/reset/stability sequences
// and random traffic against a byte-array reference model.
module tb_ram_responder;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned LAT = 2;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          reset, mov, rw, sign;
  logic [AW-1:0] addr;
  logic [1:0]    size;
  logic [31:0]   data_in, data_out;
  logic          mfc, err, busy;

  always #5 clk = ~clk;

  ram_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mov(mov), .rw(rw), .addr(addr), .size(size),
    .sign(sign), .data_in(data_in), .data_out(data_out), .mfc(mfc),
    .err(err), .busy(busy)
  );

  int passed = 0;
  int total = 0;

  logic [7:0]  modelMem [DEPTH];
  logic [31:0] modelOut;

  typedef struct {
    logic          r;
    logic [AW-1:0] a;
    logic [1:0]    s;
    logic          sg;
    logic [31:0]   d;
    logic          expErr;
    logic          chk;
    logic [31:0]   expData;
  } vecT;

  vecT vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Reference behaviour: plain byte array, big-endian, rules applied directly.
  task automatic modelApply(input logic r, input logic [AW-1:0] a, input logic [1:0] s,
                            input logic sg, input logic [31:0] d, output logic bad);
    int b;
    b = int'(a);
    bad = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    if (bad) return;
    if (!r) begin
      case (s)
        2'd0: modelMem[b] = d[7:0];
        2'd1: begin modelMem[b] = d[15:8]; modelMem[b+1] = d[7:0]; end
        default: for (int k = 0; k < 4; k++) modelMem[b+k] = d[31-8*k -: 8];
      endcase
    end else begin
      case (s)
        2'd0: modelOut = {{24{sg & modelMem[b][7]}}, modelMem[b]};
        2'd1: modelOut = {{16{sg & modelMem[b][7]}}, modelMem[b], modelMem[b+1]};
        default: modelOut = {modelMem[b], modelMem[b+1], modelMem[b+2], modelMem[b+3]};
      endcase
    end
  endtask

  // One full handshake, entered and left at a negedge with mov low.
  task automatic doReq(input logic r, input logic [AW-1:0] a, input logic [1:0] s,
                       input logic sg, input logic [31:0] d, input bit scramble,
                       input int hold, output logic gotErr, output logic [31:0] gotData);
    logic expErr;
    int n;
    modelApply(r, a, s, sg, d, expErr);
    mov = 1'b1; rw = r; addr = a; size = s; sign = sg; data_in = d;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_sample", 32'(busy), 32'd1);
    n = 0;
    while (mfc !== 1'b1 && n < 40) begin
      if (scramble) begin
        rw = 1'($urandom); addr = AW'($urandom); data_in = $urandom;
        size = 2'($urandom); sign = 1'($urandom);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("mfc_latency", 32'(n), 32'(LAT));
    check("err", 32'(err), 32'(expErr));
    check("data_out", data_out, modelOut);
    gotErr = err;
    gotData = data_out;
    for (int i = 0; i < hold; i++) begin
      addr = a + AW'(4);
      data_in = ~d;
      @(posedge clk);
      @(negedge clk);
      check("hold_mfc", 32'(mfc), 32'd1);
      check("hold_err", 32'(err), 32'(expErr));
      check("hold_data", data_out, modelOut);
    end
    mov = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("retire_mfc", 32'(mfc), 32'd0);
    check("retire_err", 32'(err), 32'd0);
    check("retire_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic          e;
    logic [31:0]   dd, pat;
    logic          rr, sg;
    logic [AW-1:0] ra;
    logic [1:0]    rs;
    int            pick;

    vecs[0]  = '{1'b0, 9'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 9'h010, 2'd2, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 9'h010, 2'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h000000DE};
    vecs[3]  = '{1'b0, 9'h021, 2'd0, 1'b0, 32'h00000080, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 9'h021, 2'd0, 1'b1, 32'h0,        1'b0, 1'b1, 32'hFFFFFF80};
    vecs[5]  = '{1'b1, 9'h021, 2'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00000080};
    vecs[6]  = '{1'b0, 9'h022, 2'd1, 1'b0, 32'h00008001, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 9'h022, 2'd1, 1'b1, 32'h0,        1'b0, 1'b1, 32'hFFFF8001};
    vecs[8]  = '{1'b0, 9'h013, 2'd2, 1'b0, 32'h12345678, 1'b1, 1'b1, 32'hFFFF8001};
    vecs[9]  = '{1'b1, 9'h010, 2'd2, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 9'h011, 2'd1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 9'h010, 2'd3, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    vecs[12] = '{1'b1, 9'h020, 2'd2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h85808001};
    vecs[13] = '{1'b1, 9'h023, 2'd0, 1'b1, 32'h0,        1'b0, 1'b1, 32'h00000001};

    reset = 1'b1; mov = 1'b0; rw = 1'b0; addr = '0; size = 2'd0; sign = 1'b0;
    data_in = 32'h0; modelOut = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_mfc", 32'(mfc), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data_out", data_out, 32'h0);
    reset = 1'b0;

    // Known fill: byte at a = a[7:0] ^ 0xA5.
    for (int w = 0; w < int'(DEPTH); w += 4) begin
      for (int k = 0; k < 4; k++) pat[31-8*k -: 8] = 8'(w + k) ^ 8'hA5;
      doReq(1'b0, AW'(w), 2'd2, 1'b0, pat, 1'b0, 0, e, dd);
    end

    for (int i = 0; i < 14; i++) begin
      doReq(vecs[i].r, vecs[i].a, vecs[i].s, vecs[i].sg, vecs[i].d, 1'b0, 0, e, dd);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].expErr));
      if (vecs[i].chk) check($sformatf("vec%0d_data", i), dd, vecs[i].expData);
    end

    // mov held in DONE: no second access even with new addr/data on the pins.
    doReq(1'b1, 9'h010, 2'd2, 1'b0, 32'h0, 1'b0, 10, e, dd);
    check("hold_read", dd, 32'hDEADBEEF);
    doReq(1'b0, 9'h030, 2'd2, 1'b0, 32'h11223344, 1'b0, 10, e, dd);
    doReq(1'b1, 9'h030, 2'd2, 1'b0, 32'h0, 1'b0, 0, e, dd);
    check("hold_write_read", dd, 32'h11223344);
    doReq(1'b1, 9'h034, 2'd2, 1'b0, 32'h0, 1'b0, 0, e, dd);
    check("hold_no_second_write", dd, 32'h91909392);

    // Reset on the edge where the write would land.
    mov = 1'b1; rw = 1'b0; addr = 9'h040; size = 2'd2; sign = 1'b0; data_in = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mov = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_mfc", 32'(mfc), 32'd0);
    check("midreset_err", 32'(err), 32'd0);
    check("midreset_busy_low", 32'(busy), 32'd0);
    check("midreset_data_out", data_out, 32'h0);
    reset = 1'b0;
    modelOut = 32'h0;
    doReq(1'b1, 9'h040, 2'd2, 1'b0, 32'h0, 1'b0, 0, e, dd);
    check("midreset_read", dd, 32'hE5E4E7E6);

    // Inputs wiggled during WAIT must not affect the latched access.
    doReq(1'b0, 9'h050, 2'd2, 1'b0, 32'hA1B2C3D4, 1'b1, 0, e, dd);
    doReq(1'b1, 9'h050, 2'd2, 1'b0, 32'h0, 1'b0, 0, e, dd);
    check("stable_write", dd, 32'hA1B2C3D4);
    doReq(1'b1, 9'h010, 2'd2, 1'b0, 32'h0, 1'b1, 0, e, dd);
    check("stable_read", dd, 32'hDEADBEEF);

    // Random traffic against the model.
    repeat (300) begin
      rr = 1'($urandom);
      sg = 1'($urandom);
      ra = AW'($urandom);
      pick = int'($urandom_range(0, 9));
      rs = (pick == 9) ? 2'd3 : 2'(pick / 3);
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      doReq(rr, ra, rs, sg, $urandom, ($urandom_range(0, 3) == 0), 0, e, dd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the CPU data-memory port: services one read or write request at a time over a four-phase MOV/MFC handshake, with configurable access latency. Byte-addressed, big-endian, supports byte/halfword/word accesses with optional sign extension on reads. It sits between the datapath's MAR/MDR registers and the data RAM array, replacing the zero-latency RAM when the control unit runs multi-cycle memory states.

## Interface
- DEPTH_BYTES, 512, memory size in bytes; power of two; address width AW = log2(DEPTH_BYTES)
- LATENCY, 2, edges from request sample to MFC assertion; legal range 1..15
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mov  in  1  memory operation valid; request strobe, held high until mfc seen
- rw  in  1  1 = read, 0 = write
- addr  in  AW  byte address
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- sign  in  1  reads only: 1 = sign-extend byte/halfword, 0 = zero-extend
- data_in  in  32  write data, right-justified for byte/halfword
- data_out  out  32  read data, right-justified
- mfc  out  1  memory function complete
- err  out  1  request rejected (misaligned or reserved size); valid while mfc=1
- busy  out  1  request accepted and not yet retired

## Operation
- States: IDLE, WAIT, DONE. busy = (state != IDLE).
- IDLE: on edge with mov=1, latch rw, addr, size, sign, data_in; compute bad = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0); load cnt = LATENCY-1; go WAIT.
- WAIT: latched values used; live inputs ignored. If cnt!=0: cnt--. If cnt==0: perform access unless bad; set mfc=1, err=bad; go DONE.
- DONE: hold mfc, err, data_out. On edge with mov=0: mfc=0, err=0, go IDLE. mov held high keeps DONE indefinitely; no second access.
- Big-endian layout: byte at a is word bits 31:24 of the aligned word containing a.
- Write byte: mem[a]=d[7:0]. Halfword: mem[a]=d[15:8], mem[a+1]=d[7:0]. Word: mem[a..a+3]=d[31:24], d[23:16], d[15:8], d[7:0].
- Read byte: data_out = {24{sign&mem[a][7]}, mem[a]}. Halfword: {16{sign&mem[a][7]}, mem[a], mem[a+1]}. Word: {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- data_out updates only on a successful read completion; writes and rejected requests leave it unchanged.
- Rejected request (bad=1): no memory change, data_out unchanged, same latency as a good request.

## Timing
- Reset values: state IDLE, mfc 0, err 0, busy 0, data_out 0, cnt 0. Memory contents unaffected by reset.
- Request sampled at edge E (IDLE, mov=1): busy high after E; mfc and err high after edge E+LATENCY; read data valid in the same cycle as mfc.
- Write takes effect at edge E+LATENCY; a read issued afterwards returns the new data.
- Retire: first edge in DONE with mov=0 clears mfc; earliest next request sample is the following edge (mov must be observed low once between requests).
- Reset asserted in WAIT: pending access dropped (write not performed); in DONE: mfc/err drop after the reset edge, memory already updated stays updated.
- Reset wins over every other condition on the same edge.
- Address wrap: word/halfword accesses are aligned, so a+1..a+3 never wrap; no out-of-range address exists.

## Test plan
- Word write/read, LATENCY=2: write 0xDEADBEEF to addr 0x010, then word read 0x010 -> mfc high exactly 2 edges after each sample; data_out=0xDEADBEEF; byte read 0x010 sign=0 -> 0x000000DE.
- Sign extension: byte write 0x80 to 0x021; byte read 0x021 sign=1 -> 0xFFFFFF80, sign=0 -> 0x00000080; halfword write 0x8001 to 0x022, read sign=1 -> 0xFFFF8001.
- Misalignment: word write 0x12345678 to 0x013 -> mfc with err=1 after 2 edges; subsequent word read 0x010 unchanged; halfword read 0x011 -> err=1, data_out unchanged; size=11 -> err=1.
- Handshake: hold mov high 10 cycles in DONE -> mfc stays 1, single access only; drop mov -> mfc=0 next edge; mov reasserted immediately after -> accepted one edge later.
- Reset mid-operation: start word write 0xCAFEF00D to 0x040, assert reset in WAIT -> all outputs reset values, read 0x040 returns prior contents.
- Input stability: change addr/data_in/rw during WAIT -> access uses values latched at request sample.
